// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO stream reader and its output queue.
package fifo_pkg;

  localparam int unsigned OUT_BUF_DEPTH = 3;

  typedef logic [1:0] buf_ptr_t;
  typedef logic [1:0] buf_occ_t;

  // Advance a queue pointer, wrapping after the last entry.
  function automatic buf_ptr_t ptr_inc(buf_ptr_t p);
    return (p == buf_ptr_t'(OUT_BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry circular queue holding words already read from the FIFO. Head entry and
// occupancy come straight from registers, so valid/data downstream are glitch-free.
module stream_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output buf_occ_t              occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
  buf_ptr_t              head_q, head_d;
  buf_ptr_t              tail_q, tail_d;
  buf_occ_t              occ_q, occ_d;

  // Pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      occ_d = occ_q + buf_occ_t'(push_i) - buf_occ_t'(pop_i);
    end
  end

  // Pointer/occupancy state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < OUT_BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  // Outputs are pure register reads.
  always_comb begin
    occ_o       = occ_q;
    valid_o     = (occ_q != '0);
    head_data_o = mem_q[head_q];
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: issues read strobes, tracks the word in
// flight, and presents returned words as a valid/ready stream with a delivery counter.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_read_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  buf_occ_t             occ;
  logic                 inflight_q, inflight_d;
  logic                 push, pop, buf_flush;
  logic [2:0]           pending;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Read issue: only when the queue can absorb every word already requested.
  // No dependence on m_ready_i, so there is no combinational path from the sink.
  always_comb begin
    pending     = {1'b0, occ} + {2'b00, inflight_q};
    fifo_read_o = rst_n_i & clk_en_i & ~flush_i & ~fifo_empty_i & (pending < 3'd3);
    pop         = clk_en_i & ~flush_i & m_valid_o & m_ready_i;
    buf_flush   = clk_en_i & flush_i;
  end

  // Capture select: FWFT data is valid in the strobe cycle, otherwise one cycle later.
  // A flush drops the in-flight word by neither capturing it nor keeping the flag.
  always_comb begin
    if (FWFT != 0) begin
      push       = fifo_read_o;
      inflight_d = 1'b0;
    end else begin
      push       = clk_en_i & ~flush_i & inflight_q;
      inflight_d = clk_en_i ? fifo_read_o : inflight_q;
    end
    cnt_d = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  // In-flight flag and delivered-word counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  stream_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (buf_flush),
    .push_i     (push),
    .push_data_i(fifo_rd_data_i),
    .pop_i      (pop),
    .occ_o      (occ),
    .valid_o    (m_valid_o),
    .head_data_o(m_data_o)
  );

  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: one reader in registered-read mode (4-bit counter) and one in FWFT mode,
// each fed by a small behavioural FIFO.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, flush;
  logic          empty0, empty1, rd0, rd1;
  logic          valid0, valid1, ready0, ready1;
  logic [DW-1:0] rd_data0, rd_data1, data0, data1;
  logic [CW-1:0] cnt0, cnt1;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          do_pop0 = 1'b0;
  logic          do_pop1 = 1'b0;
  int            total = 0;
  int            bad = 0;

  typedef struct {
    logic          ready;
    logic          rd;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .FWFT      (0),
    .CNT_WIDTH (CW)
  ) u_dut0 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .flush_i       (flush),
    .fifo_empty_i  (empty0),
    .fifo_rd_data_i(rd_data0),
    .fifo_read_o   (rd0),
    .m_data_o      (data0),
    .m_valid_o     (valid0),
    .m_ready_i     (ready0),
    .word_cnt_o    (cnt0)
  );

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .FWFT      (1),
    .CNT_WIDTH (CW)
  ) u_dut1 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .flush_i       (1'b0),
    .fifo_empty_i  (empty1),
    .fifo_rd_data_i(rd_data1),
    .fifo_read_o   (rd1),
    .m_data_o      (data1),
    .m_valid_o     (valid1),
    .m_ready_i     (ready1),
    .word_cnt_o    (cnt1)
  );

  task automatic refresh();
    empty0   = (q0.size() == 0);
    empty1   = (q1.size() == 0);
    rd_data1 = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Strobes seen by the DUTs at each edge (clk_en already folded into fifo_read_o).
  always @(posedge clk) begin
    do_pop0 <= clk_en & rd0;
    do_pop1 <= clk_en & rd1;
  end

  // Behavioural FIFOs: registered read data for u_dut0, show-ahead for u_dut1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (do_pop0 && q0.size() != 0) rd_data0 = q0.pop_front();
      if (do_pop1 && q1.size() != 0) void'(q1.pop_front());
      refresh();
    end
  end

  initial begin
    logic [DW-1:0] got[$];

    vecs = '{
      '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0},
      '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0},
      '{1'b1, 1'b1, 1'b1, 8'h11, 4'd0},
      '{1'b1, 1'b1, 1'b1, 8'h12, 4'd1},
      '{1'b1, 1'b1, 1'b1, 8'h13, 4'd2},
      '{1'b1, 1'b1, 1'b1, 8'h14, 4'd3},
      '{1'b1, 1'b1, 1'b1, 8'h15, 4'd4},
      '{1'b1, 1'b1, 1'b1, 8'h16, 4'd5},
      '{1'b1, 1'b0, 1'b1, 8'h17, 4'd6},
      '{1'b1, 1'b0, 1'b1, 8'h18, 4'd7},
      '{1'b1, 1'b0, 1'b0, 8'h00, 4'd8}
    };

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    rd_data0 = '0;
    refresh();
    @(negedge clk);
    chk("reset valid0", valid0, 0);
    chk("reset cnt0", cnt0, 0);
    chk("reset data1", data1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, registered read: table of per-cycle expectations.
    @(negedge clk);
    for (int i = 0; i < 8; i++) q0.push_back(8'h11 + DW'(i));
    refresh();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      ready0 = vecs[i].ready;
      #1;
      chk($sformatf("stream rd c%0d", i), rd0, vecs[i].rd);
      chk($sformatf("stream valid c%0d", i), valid0, vecs[i].valid);
      if (vecs[i].valid) chk($sformatf("stream data c%0d", i), data0, vecs[i].data);
      chk($sformatf("stream cnt c%0d", i), cnt0, vecs[i].cnt);
    end

    // Backpressure: three strobes then hold; release and drain in order, counter wraps.
    @(negedge clk);
    ready0 = 1'b0;
    for (int i = 0; i < 8; i++) q0.push_back(8'h21 + DW'(i));
    refresh();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("bp rd c%0d", c), rd0, (c < 3) ? 1 : 0);
      if (c >= 2) begin
        chk($sformatf("bp valid c%0d", c), valid0, 1);
        chk($sformatf("bp data c%0d", c), data0, 8'h21);
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ready0 = 1'b1;
      #1;
      chk($sformatf("drain valid k%0d", k), valid0, 1);
      chk($sformatf("drain data k%0d", k), data0, 8'h21 + k);
      chk($sformatf("drain cnt k%0d", k), cnt0, (8 + k) % 16);
    end
    @(negedge clk);
    #1;
    chk("wrap cnt", cnt0, 0);
    chk("drain done valid", valid0, 0);

    // Flush with occ=2 and a word in flight.
    @(negedge clk);
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) q0.push_back(8'h31 + DW'(i));
    refresh();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush no strobe", rd0, 0);
    chk("flush pre valid", valid0, 1);
    @(negedge clk);
    flush = 1'b0;
    ready0 = 1'b1;
    #1;
    chk("flush valid c4", valid0, 0);
    chk("flush cnt c4", cnt0, 0);
    chk("flush restrobe c4", rd0, 1);
    @(negedge clk);
    #1;
    chk("flush valid c5", valid0, 0);
    @(negedge clk);
    #1;
    chk("flush next valid", valid0, 1);
    chk("flush next data", data0, 8'h34);
    @(negedge clk);
    #1;
    chk("flush next cnt", cnt0, 1);
    chk("flush idle valid", valid0, 0);

    // Clock-enable freeze mid-stream with the sink ready.
    @(negedge clk);
    ready0 = 1'b1;
    for (int i = 0; i < 8; i++) q0.push_back(8'h41 + DW'(i));
    refresh();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      clk_en = !(c >= 4 && c <= 7);
      #1;
      if (!clk_en) begin
        chk($sformatf("freeze rd c%0d", c), rd0, 0);
        chk($sformatf("freeze data c%0d", c), data0, 8'h43);
        chk($sformatf("freeze valid c%0d", c), valid0, 1);
        chk($sformatf("freeze cnt c%0d", c), cnt0, 3);
      end
      if (valid0 && ready0 && clk_en) got.push_back(data0);
    end
    chk("freeze word count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("freeze word %0d", i), got[i], 8'h41 + i);
    chk("freeze final cnt", cnt0, 9);

    // FWFT: word lands in an empty FIFO, delivered the next cycle.
    @(negedge clk);
    ready1 = 1'b1;
    q1.push_back(8'hA5);
    refresh();
    #1;
    chk("fwft strobe", rd1, 1);
    chk("fwft valid N", valid1, 0);
    @(negedge clk);
    #1;
    chk("fwft valid N+1", valid1, 1);
    chk("fwft data N+1", data1, 8'hA5);
    chk("fwft no strobe N+1", rd1, 0);
    @(negedge clk);
    #1;
    chk("fwft valid N+2", valid1, 0);
    chk("fwft cnt", cnt1, 1);

    // Asynchronous reset mid-stream with occ=2, then an idle empty FIFO.
    @(negedge clk);
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) q0.push_back(8'h51 + DW'(i));
    refresh();
    repeat (3) @(negedge clk);
    #1;
    chk("prereset valid", valid0, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst rd", rd0, 0);
    chk("async rst valid", valid0, 0);
    chk("async rst data", data0, 0);
    chk("async rst cnt", cnt0, 0);
    q0.delete();
    refresh();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle rd c%0d", c), rd0, 0);
      chk($sformatf("idle valid c%0d", c), valid0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
